// File: rtl/seq_ctrl.sv
// Microcode sequencer: pc update, CALL/RET through an external registered return stack, HALT.
// pc latency 1 cycle; RET takes 2 cycles via RET_WAIT. stall freezes all state. Optional SEQ_CTRL_GUARD_EN adds the err/HALT stack guard.
module seq_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int START_ADR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_vld,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] target,
    input  logic             cond,
    input  logic             stall,
    output logic [WIDTH-1:0] pc,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic             sub_push,
    output logic             sub_pop,
    output logic [WIDTH-1:0] push_adr,
    input  logic [WIDTH-1:0] pop_adr
);
    localparam int DW = $clog2(DEPTH + 1);

    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_JUMP = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_BRZ  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd5;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_RET_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             err_d;
    logic             push_c, pop_c;
    logic [WIDTH-1:0] pc_inc;

    assign pc_inc = pc_q + WIDTH'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        err_d   = err;
        push_c  = 1'b0;
        pop_c   = 1'b0;
        if (!stall) begin
            case (state_q)
                S_RUN: begin
                    if (op_vld) begin
                        case (op)
                            OP_JUMP: pc_d = target;
                            OP_BRZ:  pc_d = cond ? pc_inc : target;
                            OP_CALL: begin
                                if (depth_q < DW'(DEPTH)) begin
                                    push_c  = 1'b1;
                                    pc_d    = target;
                                    depth_d = depth_q + DW'(1);
                                end else begin
`ifdef SEQ_CTRL_GUARD_EN
                                    err_d   = 1'b1;
                                    state_d = S_HALT;
`else
                                    pc_d    = target;
`endif
                                end
                            end
                            OP_RET: begin
                                if (depth_q != '0) begin
                                    state_d = S_RET_WAIT;
                                end else begin
`ifdef SEQ_CTRL_GUARD_EN
                                    err_d   = 1'b1;
                                    state_d = S_HALT;
`else
                                    pc_d    = pc_inc;
`endif
                                end
                            end
                            OP_HALT: state_d = S_HALT;
                            default: pc_d = pc_inc;
                        endcase
                    end
                end
                // The extra cycle lets the stack's registered top settle after the last push.
                S_RET_WAIT: begin
                    pc_d    = pop_adr;
                    pop_c   = 1'b1;
                    depth_d = depth_q - DW'(1);
                    state_d = S_RUN;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= WIDTH'(START_ADR);
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
        end
    end

`ifdef SEQ_CTRL_GUARD_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Stack commands are gated by reset so they drop immediately on assertion.
    assign sub_push = push_c & rst_n;
    assign sub_pop  = pop_c & rst_n;
    assign pc       = pc_q;
    assign push_adr = pc_q;
    assign busy     = (state_q == S_RET_WAIT);
    assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl with a small behavioural return stack (registered top).
module tb_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_vld = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] target = 8'h00;
    logic       cond = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] pc;
    logic       busy, halted, err, sub_push, sub_pop;
    logic [7:0] push_adr;
    logic [7:0] pop_adr;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] stk [0:7];
    int         sp;

    always #5 clk = ~clk;

    seq_ctrl #(.WIDTH(8), .DEPTH(4), .START_ADR(0)) dut (
        .clk(clk), .rst_n(rst_n), .op_vld(op_vld), .op(op), .target(target),
        .cond(cond), .stall(stall), .pc(pc), .busy(busy), .halted(halted),
        .err(err), .sub_push(sub_push), .sub_pop(sub_pop),
        .push_adr(push_adr), .pop_adr(pop_adr)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp = 0;
            pop_adr <= 8'h00;
        end else begin
            if (sub_push && sp < 8) begin
                stk[sp] = push_adr + 8'd1;
                sp = sp + 1;
            end else if (sub_pop && sp > 0) begin
                sp = sp - 1;
            end
            pop_adr <= (sp > 0) ? stk[sp-1] : 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] t,
                         input logic c, input logic s);
        @(negedge clk);
        op_vld = v; op = o; target = t; cond = c; stall = s;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; op_vld = 1'b0; stall = 1'b0;
        #1;
        check("rst_pc", pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] rets [0:3];
        // Reset state
        #2;
        check("rst_pc0", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_push", sub_push, 0);
        check("rst_pop", sub_pop, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // NEXT x3
        for (int i = 1; i <= 3; i++) begin
            drive(1, 3'd0, 8'h00, 0, 0);
            check("next_push", sub_push, 0);
            check("next_pop", sub_pop, 0);
            tick();
            check("next_pc", pc, i);
        end
        check("next_err", err, 0);

        // op_vld low holds pc
        drive(0, 3'd1, 8'h55, 0, 0);
        tick();
        check("novld_pc", pc, 3);

        // CALL / RET
        drive(1, 3'd1, 8'h10, 0, 0);
        tick();
        check("jump_pc", pc, 8'h10);
        drive(1, 3'd2, 8'h40, 0, 0);
        check("call_push", sub_push, 1);
        check("call_padr", push_adr, 8'h10);
        tick();
        check("call_pc", pc, 8'h40);
        drive(1, 3'd3, 8'h00, 0, 0);
        check("ret_nopop", sub_pop, 0);
        tick();
        check("ret_busy", busy, 1);
        check("ret_pc_hold", pc, 8'h40);
        drive(1, 3'd1, 8'h77, 0, 0);
        check("retw_pop", sub_pop, 1);
        check("retw_nopush", sub_push, 0);
        tick();
        check("ret_pc", pc, 8'h11);
        check("ret_busy_off", busy, 0);

        // Nested CALLs to depth 4, then unwind
        rets[0] = 8'h12; rets[1] = 8'h21; rets[2] = 8'h31; rets[3] = 8'h41;
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'd2, 8'h20 + 8'(i * 16), 0, 0);
            check("nest_push", sub_push, 1);
            tick();
        end
        check("nest_pc", pc, 8'h50);
        for (int i = 3; i >= 0; i--) begin
            drive(1, 3'd3, 8'h00, 0, 0);
            tick();
            check("unw_busy", busy, 1);
            drive(0, 3'd0, 8'h00, 0, 0);
            check("unw_pop", sub_pop, 1);
            tick();
            check("unw_pc", pc, rets[i]);
        end

        // RET at depth 0
        drive(1, 3'd3, 8'h00, 0, 0);
        check("uflow_nopop", sub_pop, 0);
        tick();
`ifdef SEQ_CTRL_GUARD_EN
        check("uflow_err", err, 1);
        check("uflow_halted", halted, 1);
        check("uflow_pc", pc, 8'h12);
`else
        check("uflow_err", err, 0);
        check("uflow_busy", busy, 0);
        check("uflow_pc", pc, 8'h13);
`endif
        do_reset();

        // BRZ, wrap, undefined op, HALT
        drive(1, 3'd1, 8'h05, 0, 0);
        tick();
        drive(1, 3'd4, 8'h20, 0, 0);
        tick();
        check("brz_taken", pc, 8'h20);
        drive(1, 3'd4, 8'h70, 1, 0);
        tick();
        check("brz_nottaken", pc, 8'h21);
        drive(1, 3'd1, 8'hFF, 0, 0);
        tick();
        drive(1, 3'd0, 8'h00, 0, 0);
        tick();
        check("wrap_pc", pc, 8'h00);
        drive(1, 3'd6, 8'h44, 0, 0);
        tick();
        check("op6_pc", pc, 8'h01);
        drive(1, 3'd5, 8'h00, 0, 0);
        tick();
        check("halt_halted", halted, 1);
        check("halt_pc", pc, 8'h01);
        drive(1, 3'd1, 8'h33, 0, 0);
        tick();
        check("halt_stay_pc", pc, 8'h01);
        check("halt_stay", halted, 1);
        do_reset();

        // Overflowing CALL
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'd2, 8'h80 + 8'(i), 0, 0);
            tick();
        end
        check("ovf_pre_pc", pc, 8'h83);
        drive(1, 3'd2, 8'h60, 0, 0);
        check("ovf_nopush", sub_push, 0);
        tick();
`ifdef SEQ_CTRL_GUARD_EN
        check("ovf_err", err, 1);
        check("ovf_halted", halted, 1);
        check("ovf_pc", pc, 8'h83);
`else
        check("ovf_err", err, 0);
        check("ovf_halted", halted, 0);
        check("ovf_pc", pc, 8'h60);
`endif
        do_reset();

        // Stall during RET_WAIT, then reset
        drive(1, 3'd2, 8'h40, 0, 0);
        tick();
        drive(1, 3'd3, 8'h00, 0, 0);
        tick();
        check("st_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 3'd0, 8'h00, 0, 1);
            check("st_nopop", sub_pop, 0);
            tick();
            check("st_pc", pc, 8'h40);
            check("st_busy_hold", busy, 1);
        end
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0;
        #1;
        check("st_rst_pc", pc, 0);
        check("st_rst_busy", busy, 0);
        check("st_rst_nopop", sub_pop, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 3'd0, 8'h00, 0, 0);
        tick();
        check("post_rst_pc", pc, 8'h01);
        drive(1, 3'd3, 8'h00, 0, 0);
        check("post_rst_nopop", sub_pop, 0);
        tick();
        check("post_rst_depth0", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
